// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared framebuffer geometry, sized constants, the line
//                arbiter state encoding and the line base address helper.
//  Revision    : 1.0  initial release
// ============================================================================
package fb_pkg;

    localparam int FB_W     = 160;          // pixels per line
    localparam int FB_H     = 144;          // lines
    localparam int FB_DEPTH = FB_W * FB_H;  // framebuffer words

    localparam int ADDR_W = 15;
    localparam int COL_W  = 8;
    localparam int PIX_W  = 2;

    // Constants sized to the buses they are compared against.
    localparam logic [COL_W-1:0]  LINE_LEN = COL_W'(FB_W);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(FB_W - 1);
    localparam logic [7:0]        LINE_CNT = 8'(FB_H);
    localparam logic [ADDR_W-1:0] DEPTH_L  = ADDR_W'(FB_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fb_arb_state_t;

    // First framebuffer word of a line.
    function automatic logic [ADDR_W-1:0] line_base(input logic [7:0] idx);
        return ADDR_W'(32'(idx) * 32'(FB_W));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_line_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fb_line_arbiter_if
//  Description : Bundle of the line-fetch request, pixel write requester,
//                display read port and framebuffer port of fb_line_arbiter.
//  Modports    : slave  - the arbiter
//                master - requesters, display and framebuffer memory
//  Revision    : 1.0  initial release
// ============================================================================
interface fb_line_arbiter_if;
    import fb_pkg::*;

    logic              line_req;
    logic [7:0]        line_idx;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              wr_ready;
    logic [7:0]        rd_x;
    logic [PIX_W-1:0]  rd_pixel;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_we;
    logic [PIX_W-1:0]  bram_din;
    logic [PIX_W-1:0]  bram_dout;
    logic              line_busy;
    logic              line_done;
    logic              err;

    modport slave (
        input  line_req, line_idx, wr_valid, wr_addr, wr_data, rd_x, bram_dout,
        output wr_ready, rd_pixel, bram_addr, bram_we, bram_din,
               line_busy, line_done, err
    );

    modport master (
        output line_req, line_idx, wr_valid, wr_addr, wr_data, rd_x, bram_dout,
        input  wr_ready, rd_pixel, bram_addr, bram_we, bram_din,
               line_busy, line_done, err
    );

endinterface
`default_nettype wire

// File: rtl/line_buf_2bank.sv
`default_nettype none
// ============================================================================
//  Module      : line_buf_2bank
//  Description : Two FB_W x 2-bit line banks. bank_sel_i names the front
//                (displayed) bank; writes always land in the other one.
//  Ports       : vclock, rst    clock / synchronous active-high reset
//                bank_sel_i     front bank index
//                wr_en_i/wr_col_i/wr_data_i   back bank write port
//                rd_x_i         front bank read column
//                rd_pixel_o     registered read data (0 when rd_x_i >= FB_W)
//  Revision    : 1.0  initial release
// ============================================================================
module line_buf_2bank
    import fb_pkg::*;
(
    input  wire logic             vclock,
    input  wire logic             rst,
    input  wire logic             bank_sel_i,
    input  wire logic             wr_en_i,
    input  wire logic [COL_W-1:0] wr_col_i,
    input  wire logic [PIX_W-1:0] wr_data_i,
    input  wire logic [COL_W-1:0] rd_x_i,
    output logic      [PIX_W-1:0] rd_pixel_o
);

    // Line contents survive reset; only the read register is cleared.
    logic [PIX_W-1:0] mem_q [2][FB_W];
    logic [PIX_W-1:0] rd_pixel_q;

    always_ff @(posedge vclock) begin
        if (wr_en_i) begin
            mem_q[~bank_sel_i][wr_col_i] <= wr_data_i;
        end
    end

    always_ff @(posedge vclock) begin
        if (rst) begin
            rd_pixel_q <= '0;
        end else if (rd_x_i < LINE_LEN) begin
            rd_pixel_q <= mem_q[bank_sel_i][rd_x_i];
        end else begin
            rd_pixel_q <= '0;
        end
    end

    assign rd_pixel_o = rd_pixel_q;

endmodule
`default_nettype wire

// File: rtl/fb_line_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_line_arbiter
//  Description : Shares one framebuffer port between a pixel write requester
//                and a line fetcher that copies one framebuffer line into the
//                back bank of a double-buffered line buffer, then swaps banks.
//  Ports       : vclock, rst    pixel clock / synchronous active-high reset
//                bus (slave)    line request, write handshake, display read,
//                               framebuffer port, status (busy/done/err)
//  Revision    : 1.0  initial release
// ============================================================================
module fb_line_arbiter
    import fb_pkg::*;
(
    input  wire logic         vclock,
    input  wire logic         rst,
    fb_line_arbiter_if.slave  bus
);

    fb_arb_state_t     state_q, state_d;
    logic [COL_W-1:0]  col_q,   col_d;
    logic [ADDR_W-1:0] base_q,  base_d;
    logic              front_q, front_d;
    logic              err_q,   err_d;

    logic w_idx_ok;
    logic w_start;
    logic w_grant;
    logic w_swap;
    logic w_buf_we;

    assign w_idx_ok = bus.line_idx < LINE_CNT;
    assign w_start  = (state_q == ST_IDLE) && bus.line_req && w_idx_ok;
    assign w_swap   = (state_q == ST_DONE);
    // A fetch starting this cycle takes the port ahead of a pending write.
    assign w_grant  = !rst && (((state_q == ST_IDLE) && !w_start) || w_swap);

    // Read data lags its address by one cycle, so buffer column col-1 is
    // written each cycle; DRAIN (col == FB_W) catches the final word.
    assign w_buf_we = ((state_q == ST_FETCH) && (col_q != '0)) ||
                      (state_q == ST_DRAIN);

    always_ff @(posedge vclock) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            base_q  <= '0;
            front_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            base_q  <= base_d;
            front_q <= front_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        base_d  = base_q;
        front_d = front_q;
        err_d   = err_q;

        if (bus.line_req && ((state_q != ST_IDLE) || !w_idx_ok)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d = ST_FETCH;
                    base_d  = line_base(bus.line_idx);
                    col_d   = '0;
                end
            end
            ST_FETCH: begin
                col_d = col_q + 8'd1;
                if (col_q == LAST_COL) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE: begin
                front_d = ~front_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.bram_addr = '0;
        bus.bram_we   = 1'b0;
        bus.bram_din  = '0;
        if (state_q == ST_FETCH) begin
            bus.bram_addr = base_q + ADDR_W'(col_q);
        end else if (w_grant && bus.wr_valid) begin
            // Out-of-range writes still complete the handshake but never
            // reach the memory.
            bus.bram_addr = bus.wr_addr;
            bus.bram_din  = bus.wr_data;
            bus.bram_we   = bus.wr_addr < DEPTH_L;
        end
    end

    assign bus.wr_ready  = w_grant;
    assign bus.line_busy = (state_q != ST_IDLE);
    assign bus.line_done = w_swap;
    assign bus.err       = err_q;

    // Reading through the swap lets the display see the new line on the
    // cycle right after line_done.
    line_buf_2bank u_line_buf (
        .vclock     (vclock),
        .rst        (rst),
        .bank_sel_i (w_swap ? ~front_q : front_q),
        .wr_en_i    (w_buf_we),
        .wr_col_i   (col_q - 8'd1),
        .wr_data_i  (bus.bram_dout),
        .rd_x_i     (bus.rd_x),
        .rd_pixel_o (bus.rd_pixel)
    );

endmodule
`default_nettype wire

// File: tb/tb_fb_line_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_line_arbiter
//  Description : Self-checking bench for fb_line_arbiter: write-port vector
//                table, cycle-accurate line fetch sequences and randomized
//                traffic against a line/bank reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fb_line_arbiter;
    import fb_pkg::*;

    logic vclock = 1'b0;
    logic rst    = 1'b1;
    logic do_preload = 1'b0;

    always #5 vclock = ~vclock;

    fb_line_arbiter_if bus();

    fb_line_arbiter dut (
        .vclock (vclock),
        .rst    (rst),
        .bus    (bus.slave)
    );

    // Framebuffer memory: single port, read-first, 1-cycle read latency.
    logic [1:0] fb_mem [FB_DEPTH];
    always @(posedge vclock) begin
        if (do_preload) begin
            for (int i = 0; i < FB_DEPTH; i++) fb_mem[i] <= 2'(i % 4);
        end else if (bus.bram_we) begin
            fb_mem[bus.bram_addr] <= bus.bram_din;
        end
        bus.bram_dout <= (bus.bram_addr < 15'(FB_DEPTH)) ? fb_mem[bus.bram_addr] : 2'b00;
    end

    // Reference model: framebuffer image, two line banks, front index, err.
    logic [1:0] ref_fb [FB_DEPTH];
    logic [1:0] bank_m [2][FB_W];
    bit         bank_ok [2];
    bit         sel_m;
    bit         err_m;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge vclock);
        #1;
    endtask

    task automatic mid();
        @(negedge vclock);
    endtask

    function automatic int exp_px(input int x);
        if (x >= FB_W) return 0;
        return int'(bank_m[sel_m][x]);
    endfunction

    // One line fetch with line_req at cycle 0. Optional write held from
    // cycle 0, duplicate line_req at dup_at, reset pulse at rst_at.
    task automatic run_fetch(input int idx, input bit hold_wr, input int wa,
                             input int wd, input int dup_at, input int rst_at,
                             input int x0);
        logic [1:0] line [FB_W];
        int  base;
        int  dones;
        int  old_px;
        int  new_px;
        bit  old_ok;
        base  = idx * FB_W;
        dones = 0;
        for (int x = 0; x < FB_W; x++) line[x] = ref_fb[base + x];
        old_ok = bank_ok[sel_m];
        old_px = exp_px(x0);
        new_px = int'(line[x0]);
        bus.rd_x = 8'(x0);
        for (int k = 0; k <= 163; k++) begin
            bus.line_req = (k == 0) || (k == dup_at);
            bus.line_idx = (k == 0) ? 8'(idx) : 8'($urandom_range(0, 255));
            bus.wr_valid = hold_wr && (k <= 162);
            bus.wr_addr  = 15'(wa);
            bus.wr_data  = 2'(wd);
            rst          = (k == rst_at);
            mid();
            if (bus.line_done) dones++;
            if (k == rst_at) begin
                // reset cycle itself: nothing checked
            end else if (rst_at >= 0 && k > rst_at) begin
                chk("abort_busy", int'(bus.line_busy), 0);
                chk("abort_ready", int'(bus.wr_ready), 1);
                if (k == rst_at + 1) begin
                    chk("abort_err", int'(bus.err), 0);
                    chk("abort_rdpix_rst", int'(bus.rd_pixel), 0);
                end else if (old_ok) begin
                    chk("abort_rdpix_old", int'(bus.rd_pixel), old_px);
                end
            end else begin
                chk("fetch_done", int'(bus.line_done), (k == 162) ? 1 : 0);
                chk("fetch_busy", int'(bus.line_busy), (k >= 1 && k <= 162) ? 1 : 0);
                chk("fetch_ready", int'(bus.wr_ready), (k <= 161) ? 0 : 1);
                if (k == 0) chk("fetch_err0", int'(bus.err), int'(err_m));
                if (k >= 1 && k <= 160) begin
                    chk("fetch_addr", int'(bus.bram_addr), base + k - 1);
                    chk("fetch_we", int'(bus.bram_we), 0);
                end
                if ((k == 0 && hold_wr) || k == 161) chk("fetch_we_blk", int'(bus.bram_we), 0);
                if (k == 162 && hold_wr) begin
                    chk("done_wr_we", int'(bus.bram_we), (wa < FB_DEPTH) ? 1 : 0);
                    if (wa < FB_DEPTH) begin
                        chk("done_wr_addr", int'(bus.bram_addr), wa);
                        chk("done_wr_din", int'(bus.bram_din), wd);
                    end
                end
                if (dup_at >= 0 && k == dup_at + 1) chk("dup_err", int'(bus.err), 1);
                if (k == 162 && old_ok) chk("rdpix_old", int'(bus.rd_pixel), old_px);
                if (k == 163) chk("rdpix_new", int'(bus.rd_pixel), new_px);
            end
            next_cycle();
            if (rst_at >= 0 && k == rst_at + 2) break;
        end
        bus.line_req = 1'b0;
        bus.wr_valid = 1'b0;
        rst          = 1'b0;
        chk("done_count", dones, (rst_at >= 0) ? 0 : 1);
        if (rst_at >= 0) begin
            bank_ok[~sel_m] = 1'b0;
            sel_m = 1'b0;
            err_m = 1'b0;
        end else begin
            for (int x = 0; x < FB_W; x++) bank_m[~sel_m][x] = line[x];
            bank_ok[~sel_m] = 1'b1;
            sel_m = ~sel_m;
            if (hold_wr && wa < FB_DEPTH) ref_fb[wa] = 2'(wd);
            if (dup_at >= 0) err_m = 1'b1;
        end
    endtask

    task automatic read_all();
        for (int x = 0; x < FB_W + 4; x++) begin
            bus.rd_x = 8'(x);
            next_cycle();
            mid();
            chk("rdpix_sweep", int'(bus.rd_pixel), exp_px(x));
            next_cycle();
        end
    endtask

    task automatic rand_idle(input int n);
        int  px;
        bit  pok;
        px  = 0;
        pok = 1'b0;
        for (int i = 0; i < n; i++) begin
            int  a;
            int  d;
            int  x;
            bit  v;
            bit  we;
            v = 1'($urandom % 2);
            a = ($urandom % 4 == 0) ? int'($urandom_range(FB_DEPTH, 32767))
                                    : int'($urandom_range(0, FB_DEPTH - 1));
            d = int'($urandom % 4);
            x = int'($urandom_range(0, 175));
            bus.wr_valid = v;
            bus.wr_addr  = 15'(a);
            bus.wr_data  = 2'(d);
            bus.rd_x     = 8'(x);
            mid();
            we = v && (a < FB_DEPTH);
            chk("idle_ready", int'(bus.wr_ready), 1);
            chk("idle_we", int'(bus.bram_we), we ? 1 : 0);
            if (we) begin
                chk("idle_addr", int'(bus.bram_addr), a);
                chk("idle_din", int'(bus.bram_din), d);
            end
            if (!v) chk("idle_addr0", int'(bus.bram_addr), 0);
            if (pok && (px >= FB_W || bank_ok[sel_m])) chk("idle_rdpix", int'(bus.rd_pixel), exp_px(px));
            if (we) ref_fb[a] = 2'(d);
            px  = x;
            pok = 1'b1;
            next_cycle();
        end
        bus.wr_valid = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [14:0] a;
        logic [1:0]  d;
        logic        e_rdy;
        logic        e_we;
        logic [14:0] e_addr;
        logic [1:0]  e_din;
    } wvec_t;

    wvec_t tbl [6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.line_req = 1'b0;
        bus.line_idx = '0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_x     = '0;
        for (int i = 0; i < FB_DEPTH; i++) ref_fb[i] = 2'(i % 4);
        bank_ok[0] = 1'b0;
        bank_ok[1] = 1'b0;
        sel_m = 1'b0;
        err_m = 1'b0;

        // Reset and preload.
        rst = 1'b1;
        do_preload = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        do_preload = 1'b0;
        rst = 1'b0;
        mid();
        chk("rst_busy", int'(bus.line_busy), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_done", int'(bus.line_done), 0);
        chk("rst_ready", int'(bus.wr_ready), 1);
        chk("rst_we", int'(bus.bram_we), 0);
        chk("rst_addr", int'(bus.bram_addr), 0);
        chk("rst_din", int'(bus.bram_din), 0);
        chk("rst_rdpix", int'(bus.rd_pixel), 0);
        next_cycle();

        // Write port vectors in IDLE.
        tbl[0] = '{1'b0, 15'd0,     2'd0, 1'b1, 1'b0, 15'd0,     2'd0};
        tbl[1] = '{1'b1, 15'd5,     2'd2, 1'b1, 1'b1, 15'd5,     2'd2};
        tbl[2] = '{1'b1, 15'd23040, 2'd3, 1'b1, 1'b0, 15'd0,     2'd0};
        tbl[3] = '{1'b1, 15'd23039, 2'd0, 1'b1, 1'b1, 15'd23039, 2'd0};
        tbl[4] = '{1'b1, 15'd32767, 2'd1, 1'b1, 1'b0, 15'd0,     2'd0};
        tbl[5] = '{1'b0, 15'd100,   2'd3, 1'b1, 1'b0, 15'd0,     2'd0};
        for (int i = 0; i < 6; i++) begin
            bus.wr_valid = tbl[i].v;
            bus.wr_addr  = tbl[i].a;
            bus.wr_data  = tbl[i].d;
            mid();
            chk("vec_ready", int'(bus.wr_ready), int'(tbl[i].e_rdy));
            chk("vec_we", int'(bus.bram_we), int'(tbl[i].e_we));
            if (tbl[i].e_we || !tbl[i].v) begin
                chk("vec_addr", int'(bus.bram_addr), int'(tbl[i].e_addr));
                chk("vec_din", int'(bus.bram_din), int'(tbl[i].e_din));
            end
            if (tbl[i].e_we) ref_fb[tbl[i].a] = tbl[i].d;
            next_cycle();
        end
        bus.wr_valid = 1'b0;

        // Line 0, then check the written pixel explicitly.
        run_fetch(0, 1'b0, 0, 0, -1, -1, 5);
        read_all();
        bus.rd_x = 8'd5;
        next_cycle();
        mid();
        chk("rdpix_x5", int'(bus.rd_pixel), 2);
        next_cycle();

        // Last line with a write held across the fetch.
        run_fetch(143, 1'b1, 22883, 3, -1, -1, 17);

        // Out-of-range line index in IDLE.
        bus.line_req = 1'b1;
        bus.line_idx = 8'd200;
        next_cycle();
        bus.line_req = 1'b0;
        mid();
        chk("badidx_err", int'(bus.err), 1);
        chk("badidx_busy1", int'(bus.line_busy), 0);
        next_cycle();
        mid();
        chk("badidx_busy2", int'(bus.line_busy), 0);
        chk("badidx_done", int'(bus.line_done), 0);
        next_cycle();
        err_m = 1'b1;

        // Duplicate request mid-fetch, then one more to get even swaps.
        run_fetch(7, 1'b0, 0, 0, 50, -1, 100);
        run_fetch(int'($urandom_range(0, FB_H - 1)), 1'b0, 0, 0, -1, -1, 3);

        // Reset abort at cycle 80, then a normal fetch.
        run_fetch(int'($urandom_range(0, FB_H - 1)), 1'b0, 0, 0, -1, 80, 42);
        run_fetch(int'($urandom_range(0, FB_H - 1)), 1'b0, 0, 0, -1, -1, 159);
        read_all();

        // Randomized traffic.
        rand_idle(300);
        for (int r = 0; r < 3; r++) begin
            run_fetch(int'($urandom_range(0, FB_H - 1)), 1'($urandom % 2),
                      int'($urandom_range(0, 32767)), int'($urandom % 4),
                      -1, -1, int'($urandom_range(0, FB_W - 1)));
            rand_idle(50);
        end
        read_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
